// File: rtl/gate2_pkg.sv
// Shared definitions for the two-input gate sweep: response bit map,
// sweep FSM state encoding and the golden gate model.
package gate2_pkg;

  // Bit positions of each gate function within the 6-bit response word
  localparam int Z_AND  = 5;
  localparam int Z_NAND = 4;
  localparam int Z_OR   = 3;
  localparam int Z_NOR  = 2;
  localparam int Z_XOR  = 1;
  localparam int Z_XNOR = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } gate2_sweep_state_t;

  // Expected response of a correct two-input gate block for inputs a, b
  function automatic logic [5:0] gate2_expect(input logic a, input logic b);
    logic [5:0] z;
    z         = 6'd0;
    z[Z_AND]  = a & b;
    z[Z_NAND] = ~(a & b);
    z[Z_OR]   = a | b;
    z[Z_NOR]  = ~(a | b);
    z[Z_XOR]  = a ^ b;
    z[Z_XNOR] = ~(a ^ b);
    return z;
  endfunction

endpackage

// File: rtl/gate2_ref.sv
// Combinational golden model of the two-input gate block.
module gate2_ref
  import gate2_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [5:0] z_exp
);

  assign z_exp = gate2_expect(a, b);

endmodule

// File: rtl/gate2_sweep.sv
// Self-checking stimulus sequencer for the two-input gate block.
// Drives {a,b} through 00,01,10,11, holding each HOLD_CYCLES cycles, and
// compares the gate response z with the golden model on the last cycle of
// each hold. Results: per-vector fail map, mismatch count and pass flag.
// Optional build macro GATE2_SWEEP_STOP_ON_FAIL_EN: end the sweep on the
// first mismatching vector instead of running all four.
module gate2_sweep
  import gate2_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] z,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  gate2_sweep_state_t state, state_nxt;

  logic [1:0]       idx, idx_nxt, idx_inc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_nxt, b_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [2:0]       err_nxt;
  logic [3:0]       fail_nxt;
  logic [5:0]       z_exp;
  logic             compare;
  logic             mismatch;
  logic             stop;

  gate2_ref u_ref (
    .a     (a),
    .b     (b),
    .z_exp (z_exp)
  );

  // z follows a/b combinationally, so the hold window is pure settle slack
  assign compare  = (state == RUN) && (cnt == CNT_LAST);
  assign mismatch = (z != z_exp);
  assign idx_inc  = idx + 2'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Vector index, hold counter, gate drive and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= 2'd0;
      cnt      <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 3'd0;
      fail_vec <= 4'd0;
    end else begin
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      a        <= a_nxt;
      b        <= b_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      err_cnt  <= err_nxt;
      fail_vec <= fail_nxt;
    end
  end

  // Next-state and next-register values; everything holds unless updated
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pass_nxt  = pass;
    err_nxt   = err_cnt;
    fail_nxt  = fail_vec;
    stop      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          busy_nxt  = 1'b1;
          pass_nxt  = 1'b0;
          err_nxt   = 3'd0;
          fail_nxt  = 4'd0;
        end
      end

      RUN: begin
        if (compare) begin
          if (mismatch) begin
            fail_nxt[idx] = 1'b1;
            err_nxt       = err_cnt + 3'd1;
          end
`ifdef GATE2_SWEEP_STOP_ON_FAIL_EN
          stop = (idx == 2'd3) || mismatch;
`else
          stop = (idx == 2'd3);
`endif
          if (stop) begin
            // Result flags appear together with the done pulse and include
            // the vector compared on this edge
            state_nxt = FINISH;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == 3'd0);
          end else begin
            idx_nxt = idx_inc;
            a_nxt   = idx_inc[1];
            b_nxt   = idx_inc[0];
            cnt_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      FINISH: begin
        // done lasts exactly this one cycle; start is not accepted here
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate2_sweep.sv
// Bench for gate2_sweep: a behavioural gate (with selectable faults) closes
// the loop; table-driven sweeps are scored through an expected-result queue,
// plus hand-written sequences for H=1, start re-pulse and mid-sweep reset.
module tb_gate2_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start10, start1;
  logic [5:0] z10, z1;
  logic       a10, b10, busy10, done10, pass10;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err10, err1;
  logic [3:0] fail10, fail1;
  int         fault10;

  int n_cmp = 0;
  int n_bad = 0;

  // Gate under test: fault 0 correct, 1 XOR stuck-at-0, 2 all zero, 3 AND stuck-at-1
  function automatic logic [5:0] gate_model(input logic a, input logic b, input int fault);
    logic [5:0] z;
    z = {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b)};
    if (fault == 1) z[1] = 1'b0;
    if (fault == 2) z = 6'd0;
    if (fault == 3) z[5] = 1'b1;
    return z;
  endfunction

  always_comb z10 = gate_model(a10, b10, fault10);
  always_comb z1  = gate_model(a1, b1, 0);

  gate2_sweep #(.HOLD_CYCLES(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .z(z10),
    .a(a10), .b(b10), .busy(busy10), .done(done10), .pass(pass10),
    .err_cnt(err10), .fail_vec(fail10)
  );

  gate2_sweep #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .z(z1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fail1)
  );

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [3:0] fail;
    logic [1:0] ab;
    int         lat;
  } exp_t;

  typedef struct {
    int   fault;
    exp_t e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full sweep on the H=10 instance, scored through the queue
  task automatic run_sweep(input string name, input exp_t e);
    exp_t got;
    bit   found;
    int   lat;
    sb_q.push_back(e);
    start10 = 1'b1;
    step();
    start10 = 1'b0;
    check({name, "_busy0"}, busy10, 1);
    check({name, "_ab0"}, {a10, b10}, 2'b00);
    found = 0;
    lat   = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (done10) begin
        found = 1;
        lat   = k;
        break;
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no done within 100 cycles, required done at %0d", name, e.lat);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_sb: done with empty scoreboard", name);
    end else begin
      got = sb_q.pop_front();
      check({name, "_lat"}, lat, got.lat);
      check({name, "_pass"}, pass10, got.pass);
      check({name, "_err"}, err10, got.err);
      check({name, "_fail"}, fail10, got.fail);
      check({name, "_ab"}, {a10, b10}, got.ab);
      check({name, "_busyd"}, busy10, 0);
      step();
      check({name, "_done1cy"}, done10, 0);
      check({name, "_passhold"}, pass10, got.pass);
      step();
    end
  endtask

  initial begin
    int n_done;
    int done_at;

    rst_n   = 1'b0;
    start10 = 1'b0;
    start1  = 1'b0;
    fault10 = 0;
    step();
    step();

    // Reset state
    check("rst_ab",   {a10, b10}, 2'b00);
    check("rst_busy", busy10, 0);
    check("rst_done", done10, 0);
    check("rst_pass", pass10, 0);
    check("rst_err",  err10, 0);
    check("rst_fail", fail10, 0);
    check("rst_h1",   {a1, b1, busy1, done1, pass1, err1, fail1}, 0);
    rst_n = 1'b1;
    step();

    tbl[0] = '{fault: 0, e: '{pass: 1'b1, err: 3'd0, fail: 4'b0000, ab: 2'b11, lat: 40}};
`ifdef GATE2_SWEEP_STOP_ON_FAIL_EN
    tbl[1] = '{fault: 1, e: '{pass: 1'b0, err: 3'd1, fail: 4'b0010, ab: 2'b01, lat: 20}};
    tbl[2] = '{fault: 2, e: '{pass: 1'b0, err: 3'd1, fail: 4'b0001, ab: 2'b00, lat: 10}};
    tbl[3] = '{fault: 3, e: '{pass: 1'b0, err: 3'd1, fail: 4'b0001, ab: 2'b00, lat: 10}};
`else
    tbl[1] = '{fault: 1, e: '{pass: 1'b0, err: 3'd2, fail: 4'b0110, ab: 2'b11, lat: 40}};
    tbl[2] = '{fault: 2, e: '{pass: 1'b0, err: 3'd4, fail: 4'b1111, ab: 2'b11, lat: 40}};
    tbl[3] = '{fault: 3, e: '{pass: 1'b0, err: 3'd3, fail: 4'b0111, ab: 2'b11, lat: 40}};
`endif

    for (int i = 0; i < 4; i++) begin
      fault10 = tbl[i].fault;
      run_sweep($sformatf("tbl%0d", i), tbl[i].e);
    end

    // Start re-pulsed during vector 2 is ignored; vector timing along the way
    fault10 = 0;
    start10 = 1'b1;
    step();
    start10 = 1'b0;
    n_done  = 0;
    done_at = 0;
    for (int k = 1; k <= 60; k++) begin
      start10 = (k == 25);
      step();
      if (done10) begin
        n_done++;
        done_at = k;
      end
      if (k == 5)  check("vec_ab_5",  {a10, b10}, 2'b00);
      if (k == 15) check("vec_ab_15", {a10, b10}, 2'b01);
      if (k == 25) check("vec_ab_25", {a10, b10}, 2'b10);
      if (k == 35) check("vec_ab_35", {a10, b10}, 2'b11);
    end
    start10 = 1'b0;
    check("repulse_ndone", n_done, 1);
    check("repulse_edge", done_at, 40);
    check("repulse_pass", pass10, 1);

    // Reset for one edge during vector 2 of a failing sweep
    fault10 = 1;
    start10 = 1'b1;
    step();
    start10 = 1'b0;
    for (int k = 1; k <= 25; k++) step();
    check("mid_err_pre", err10, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_busy", busy10, 0);
    check("mid_ab",   {a10, b10}, 2'b00);
    check("mid_err",  err10, 0);
    check("mid_fail", fail10, 0);
    check("mid_done", done10, 0);
    n_done = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (done10) n_done++;
    end
    check("mid_nodone", n_done, 0);
    fault10 = 0;
    run_sweep("post_rst", '{pass: 1'b1, err: 3'd0, fail: 4'b0000, ab: 2'b11, lat: 40});

    // H=1 with start held high: done at edge 4, next sweep after FINISH
    start1 = 1'b1;
    step();
    check("h1_busy0", busy1, 1);
    n_done = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done1) n_done++;
      if (k == 3)  check("h1_done3", done1, 0);
      if (k == 4)  check("h1_done4", done1, 1);
      if (k == 4)  check("h1_pass4", pass1, 1);
      if (k == 4)  check("h1_ab4", {a1, b1}, 2'b11);
      if (k == 5)  check("h1_busy5", busy1, 0);
      if (k == 6)  check("h1_busy6", busy1, 1);
      if (k == 6)  check("h1_pass6", pass1, 0);
      if (k == 10) check("h1_done10", done1, 1);
    end
    start1 = 1'b0;
    check("h1_ndone", n_done, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
